fir_phase_decimator: RTL and testbench
======================================

# fir_phase_decimator

Parametrised symbol-phase decimator at the output of the TX/RX polyphase FIR. Accepts NCH channels of W-bit oversampled samples at OS samples per symbol. Keeps exactly one sample per symbol, at a runtime-selectable phase, and emits it both as the full soft sample and as a hard-decision sign bit per channel. The phase select is applied only on symbol boundaries. It replaces the fixed 4-phase, 8-bit, single-channel, sign-only selector.

## Interface
Parameters:
- `OS`, 4: oversampling factor (samples per symbol), ≥2
- `W`, 8: sample width, signed two's complement
- `NCH`, 2: channel count (I/Q = 2)
- `PW`, $clog2(OS): phase-select width

Ports:
- `clock`  in  1  single clock, rising edge
- `i_reset_n`  in  1  asynchronous, active-low reset
- `i_enable`  in  1  global enable; when 0 all state holds
- `i_valid`  in  1  input sample strobe
- `i_data`  in  NCH*W  channel k at [k*W +: W], signed
- `i_fase`  in  PW  requested phase, 0..OS-1
- `i_sync`  in  1  symbol-alignment pulse; forces the counter to 0
- `i_bypass`  in  1  1 = pass every sample (no decimation)
- `o_data`  out  NCH*W  selected soft samples
- `o_bit`  out  NCH  sign bit of each selected sample
- `o_valid`  out  1  one-cycle strobe, output sample valid
- `o_phase`  out  PW  phase currently in effect
- `o_phase_err`  out  1  one-cycle pulse, out-of-range `i_fase` rejected

## Operation
- Accept = `i_enable && i_valid`. Nothing advances without accept, except `o_valid`/`o_phase_err` clearing.
- Counter `cnt` (PW bits) is incremented on each accept and wraps OS-1 → 0.
- Select: on accept with `cnt == phase_q`, register all NCH samples into `o_data`, their MSBs into `o_bit`, and assert `o_valid` next cycle.
- Phase load:
  - `phase_q` loads `i_fase` only on an accept with `cnt == OS-1` (symbol boundary). This prevents a dropped or duplicated symbol on a phase change.
  - If `i_fase ≥ OS` (possible when OS is not a power of 2), `phase_q` holds and `o_phase_err` pulses.
- `i_sync` with accept: the current sample is treated as cnt=0. Selection is evaluated against 0, and `cnt` becomes 1 (0 if OS=1 is impossible, since OS≥2). `i_sync` also loads `phase_q` from `i_fase`, with the same range check. `i_sync` without accept sets `cnt` to 0 and nothing else.
- Bypass: every accept produces an output; `cnt`/`phase_q` continue updating as normal so decimation resumes aligned when bypass drops.
- Mid-symbol `i_enable` low: `cnt`, `phase_q` and outputs freeze; `o_valid` is forced 0.
- Reset values (async, on `i_reset_n` low): `cnt`=0, `phase_q`=0, `o_data`=0, `o_bit`=0, `o_valid`=0, `o_phase_err`=0; `o_phase`=0.

## Timing
- Latency: accept at edge n with select true → `o_data`/`o_bit`/`o_valid` valid after edge n+1, i.e. one register stage.
- `o_valid` is high for exactly one cycle per selected sample. Back-to-back outputs occur only in bypass with continuous `i_valid`.
- `o_data`/`o_bit` hold their last value between strobes.
- A phase change takes effect for the first symbol after the boundary sample. `o_phase` reflects `phase_q` after the loading edge.
- Simultaneous `i_sync` and the boundary: `i_sync` wins, with a single load of `phase_q`.
- Reset deassertion is synchronised externally. The first accept after reset sees cnt=0 and phase=0, so it is selected.

## Structure
- Package `fir_dec_pkg`: default OS/W/NCH constants and a `phase_t` width helper. The TX filter top and this block share it.
- Sub-module `os_phase_counter`: `cnt`, wrap, sync and boundary flag, plus the `phase_q` load/range check. The top holds per-channel capture (generate over NCH) and output registers.

## Test plan
- Reset, then continuous valid, OS=4, i_fase=2, ch0 ramp 0,1,2,… → o_valid on samples 2,6,10. ch0 = 2,6,10; o_bit=0.
- Ch1 = −5 at selected phase → o_data ch1 = 8'hFB, o_bit[1]=1, one cycle after accept.
- Change i_fase 2→0 while cnt=1 → next outputs at samples 6 (old phase), then 8, 12. No skipped or double symbol.
- OS=3, i_fase=3 at the boundary → o_phase_err pulses 1 cycle, o_phase stays at its prior value.
- i_sync on sample 5 with i_fase=1 → sample 5 treated as cnt=0. Outputs at samples 6, 9, 12.
- i_enable low for 3 cycles mid-symbol, then i_bypass=1 → state frozen, no o_valid. With bypass, o_valid is asserted on every accepted sample. `i_reset_n` low mid-stream clears all outputs immediately.

Source files
------------

// File: rtl/fir_phase_decimator_pkg.sv
// Shared constants for the polyphase FIR chain: default geometry and the
// phase-select width helper used by the TX filter top and the decimator.
package fir_dec_pkg;

  localparam int unsigned DEF_OS  = 4;
  localparam int unsigned DEF_W   = 8;
  localparam int unsigned DEF_NCH = 2;

  function automatic int unsigned phase_w(input int unsigned os);
    return (os > 1) ? $clog2(os) : 1;
  endfunction

endpackage

// File: rtl/fir_phase_decimator_if.sv
// Sample-stream bundle for the symbol-phase decimator: oversampled input side
// and decimated soft/hard output side.
interface fir_phase_decimator_if
  import fir_dec_pkg::*;
#(
  parameter int unsigned NCH = DEF_NCH,
  parameter int unsigned W   = DEF_W,
  parameter int unsigned PW  = phase_w(DEF_OS)
);
  logic               i_valid;
  logic [NCH*W-1:0]   i_data;
  logic [PW-1:0]      i_fase;
  logic               i_sync;
  logic               i_bypass;
  logic [NCH*W-1:0]   o_data;
  logic [NCH-1:0]     o_bit;
  logic               o_valid;
  logic [PW-1:0]      o_phase;
  logic               o_phase_err;

  modport master (
    output i_valid, i_data, i_fase, i_sync, i_bypass,
    input  o_data, o_bit, o_valid, o_phase, o_phase_err
  );

  modport slave (
    input  i_valid, i_data, i_fase, i_sync, i_bypass,
    output o_data, o_bit, o_valid, o_phase, o_phase_err
  );
endinterface

// File: rtl/fir_phase_decimator_counter.sv
// Symbol-position counter with sync alignment and a phase register that only
// reloads on a symbol boundary (or sync), rejecting out-of-range phases.
module os_phase_counter
  import fir_dec_pkg::*;
#(
  parameter int unsigned OS = DEF_OS,
  parameter int unsigned PW = phase_w(OS)
) (
  input  logic          clock,
  input  logic          i_reset_n,
  input  logic          i_enable,
  input  logic          i_accept,
  input  logic          i_sync,
  input  logic [PW-1:0] i_fase,
  output logic [PW-1:0] o_cnt_eff,
  output logic [PW-1:0] o_phase,
  output logic          o_phase_err
);
  localparam logic [PW-1:0] LAST   = PW'(OS - 1);
  localparam logic [PW:0]   OS_EXT = (PW + 1)'(OS);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] phase_q;
  logic          boundary;
  logic          load;
  logic          fase_ok;

  // Sync re-labels the current sample as position 0; since OS >= 2 it can
  // never also be the boundary, so sync and boundary give a single load.
  always_comb begin
    o_cnt_eff = i_sync ? '0 : cnt_q;
    boundary  = (o_cnt_eff == LAST);
    load      = i_accept && (i_sync || boundary);
    fase_ok   = ({1'b0, i_fase} < OS_EXT);
  end

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q       <= '0;
      phase_q     <= '0;
      o_phase_err <= 1'b0;
    end else begin
      o_phase_err <= load && !fase_ok;
      if (i_accept) begin
        cnt_q <= boundary ? '0 : o_cnt_eff + PW'(1);
      end else if (i_enable && i_sync) begin
        cnt_q <= '0;
      end
      if (load && fase_ok) begin
        phase_q <= i_fase;
      end
    end
  end

  assign o_phase = phase_q;
endmodule

// File: rtl/fir_phase_decimator.sv
// Symbol-phase decimator: keeps one sample per symbol at the selected phase
// (or every sample in bypass) and registers soft samples plus sign bits.
module fir_phase_decimator
  import fir_dec_pkg::*;
#(
  parameter int unsigned OS  = DEF_OS,
  parameter int unsigned W   = DEF_W,
  parameter int unsigned NCH = DEF_NCH,
  parameter int unsigned PW  = phase_w(OS)
) (
  input  logic                  clock,
  input  logic                  i_reset_n,
  input  logic                  i_enable,
  fir_phase_decimator_if.slave  bus
);
  logic          accept;
  logic          take;
  logic [PW-1:0] cnt_eff;
  logic [PW-1:0] phase_q;
  logic          phase_err;
  logic [W-1:0]  cap_q [NCH];

  assign accept = i_enable && bus.i_valid;
  assign take   = accept && (bus.i_bypass || (cnt_eff == phase_q));

  os_phase_counter #(
    .OS (OS),
    .PW (PW)
  ) u_counter (
    .clock       (clock),
    .i_reset_n   (i_reset_n),
    .i_enable    (i_enable),
    .i_accept    (accept),
    .i_sync      (bus.i_sync),
    .i_fase      (bus.i_fase),
    .o_cnt_eff   (cnt_eff),
    .o_phase     (phase_q),
    .o_phase_err (phase_err)
  );

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    always_ff @(posedge clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
        cap_q[k] <= '0;
      end else if (take) begin
        cap_q[k] <= bus.i_data[k*W +: W];
      end
    end
  end

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bus.o_valid <= 1'b0;
    end else begin
      bus.o_valid <= take;
    end
  end

  always_comb begin
    bus.o_data = '0;
    bus.o_bit  = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      bus.o_data[k*W +: W] = cap_q[k];
      bus.o_bit[k]         = cap_q[k][W-1];
    end
  end

  assign bus.o_phase     = phase_q;
  assign bus.o_phase_err = phase_err;
endmodule

// File: tb/tb_fir_phase_decimator.sv
// Bench for fir_phase_decimator: an OS=4 and an OS=3 instance share one
// directed stimulus stream and are checked against a per-symbol model.
module tb_fir_phase_decimator;
  localparam int OSM [2] = '{4, 3};

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       en    = 1'b0;
  logic       vld   = 1'b0;
  logic [15:0] data = '0;
  logic [1:0] fase  = '0;
  logic       sync  = 1'b0;
  logic       byp   = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int q4[$];
  int q3[$];

  always #5 clk = ~clk;

  fir_phase_decimator_if #(.NCH(2), .W(8), .PW(2)) if4 ();
  fir_phase_decimator_if #(.NCH(2), .W(8), .PW(2)) if3 ();

  assign if4.i_valid = vld;  assign if3.i_valid = vld;
  assign if4.i_data = data;  assign if3.i_data = data;
  assign if4.i_fase = fase;  assign if3.i_fase = fase;
  assign if4.i_sync = sync;  assign if3.i_sync = sync;
  assign if4.i_bypass = byp; assign if3.i_bypass = byp;

  fir_phase_decimator #(.OS(4), .W(8), .NCH(2), .PW(2)) dut4 (
    .clock(clk), .i_reset_n(rst_n), .i_enable(en), .bus(if4.slave));
  fir_phase_decimator #(.OS(3), .W(8), .NCH(2), .PW(2)) dut3 (
    .clock(clk), .i_reset_n(rst_n), .i_enable(en), .bus(if3.slave));

  logic [15:0] od [2];
  logic [1:0]  ob [2];
  logic        ov [2];
  logic        oe [2];
  logic [1:0]  op [2];
  assign od[0] = if4.o_data;      assign od[1] = if3.o_data;
  assign ob[0] = if4.o_bit;       assign ob[1] = if3.o_bit;
  assign ov[0] = if4.o_valid;     assign ov[1] = if3.o_valid;
  assign oe[0] = if4.o_phase_err; assign oe[1] = if3.o_phase_err;
  assign op[0] = if4.o_phase;     assign op[1] = if3.o_phase;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic check_list(input string nm, input int got[$], input int exp[$]);
    check({nm, "_len"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      check($sformatf("%s[%0d]", nm, i), got[i], exp[i]);
  endtask

  // Model: position in symbol, phase in effect, expected output registers.
  int          pos [2] = '{0, 0};
  int          ph  [2] = '{0, 0};
  logic [15:0] e_data [2] = '{16'h0, 16'h0};
  logic        e_valid [2] = '{1'b0, 1'b0};
  logic        e_err [2] = '{1'b0, 1'b0};

  always @(posedge clk or negedge rst_n) begin
    int p;
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        pos[m] = 0; ph[m] = 0; e_data[m] = '0; e_valid[m] = 1'b0; e_err[m] = 1'b0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        e_valid[m] = 1'b0;
        e_err[m]   = 1'b0;
        if (en && vld) begin
          p = sync ? 0 : pos[m];
          if (byp || p == ph[m]) begin
            e_data[m]  = data;
            e_valid[m] = 1'b1;
          end
          if (sync || p == OSM[m] - 1) begin
            if (int'(fase) < OSM[m]) ph[m] = int'(fase);
            else e_err[m] = 1'b1;
          end
          pos[m] = (p + 1) % OSM[m];
        end else if (en && sync) begin
          pos[m] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      check($sformatf("os%0d_valid", OSM[m]), ov[m], e_valid[m]);
      check($sformatf("os%0d_perr", OSM[m]), oe[m], e_err[m]);
      check($sformatf("os%0d_phase", OSM[m]), op[m], ph[m]);
      check($sformatf("os%0d_data", OSM[m]), od[m], e_data[m]);
      check($sformatf("os%0d_bit", OSM[m]), ob[m], {e_data[m][15], e_data[m][7]});
      if (ov[m]) begin
        if (m == 0) q4.push_back(int'(od[m][7:0]));
        else        q3.push_back(int'(od[m][7:0]));
      end
    end
  end

  task automatic send(input logic v, input logic [7:0] d0, input logic [7:0] d1,
                      input logic [1:0] f, input logic s);
    vld = v; data = {d1, d0}; fase = f; sync = s;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int ex[$];
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_valid", if4.o_valid, 1'b0);
    check("rst_data", if4.o_data, 16'h0);
    check("rst_phase", if3.o_phase, 2'd0);
    check("rst_perr", if3.o_phase_err, 1'b0);
    rst_n = 1'b1;
    en    = 1'b1;

    // Warm-up: first accept after reset is selected at phase 0.
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 8'(100 + i), 8'd3, 2'd2, 1'b0);
      if (i == 0) begin
        check("first_sel_valid", if4.o_valid, 1'b1);
        check("first_sel_data", if4.o_data, 16'h0364);
      end
    end

    // Ramp aligned by sync at 0; phase 2, then 0 requested mid-symbol at n=5.
    for (int n = 0; n < 14; n++) begin
      send(1'b1, 8'(n), (n == 2) ? 8'hFB : 8'd3, (n < 5) ? 2'd2 : 2'd0, n == 0);
      if (n == 0) begin
        ex = '{100};
        check_list("os4_warm", q4, ex);
        q4.delete(); q3.delete();
      end
      if (n == 2) begin
        check("neg_ch1_data", if4.o_data, 16'hFB02);
        check("neg_ch1_bit", if4.o_bit, 2'b10);
        check("neg_ch1_valid", if4.o_valid, 1'b1);
      end
      if (n == 3) begin
        check("strobe_one_cycle", if4.o_valid, 1'b0);
        check("data_hold", if4.o_data, 16'hFB02);
      end
    end

    // OS=3: sync on sample 5 with phase 1.
    for (int m = 0; m < 13; m++) begin
      send(1'b1, 8'(m), 8'd7, (m < 5) ? 2'd2 : 2'd1, m == 5);
      if (m == 0) begin
        ex = '{2, 6, 8, 12};
        check_list("os4_phase_change", q4, ex);
      end
      if (m == 5) begin
        check("sync_phase", if3.o_phase, 2'd1);
        check("sync_not_sel", if3.o_valid, 1'b0);
        q3.delete();
      end
    end

    // OS=3 boundary with out-of-range phase 3.
    send(1'b1, 8'd13, 8'd7, 2'd3, 1'b0);
    ex = '{6, 9, 12};
    check_list("os3_sync", q3, ex);
    check("perr_pulse", if3.o_phase_err, 1'b1);
    check("perr_phase_hold", if3.o_phase, 2'd1);
    send(1'b1, 8'd14, 8'd7, 2'd3, 1'b0);
    check("perr_one_cycle", if3.o_phase_err, 1'b0);
    send(1'b1, 8'd15, 8'd7, 2'd1, 1'b0);
    send(1'b1, 8'd16, 8'd7, 2'd1, 1'b0);

    // Enable low for 3 cycles mid-symbol, then bypass.
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 8'd50, 8'd51, 2'd1, 1'b0);
      check("frozen_valid4", if4.o_valid, 1'b0);
      check("frozen_valid3", if3.o_valid, 1'b0);
    end
    en  = 1'b1;
    byp = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(1'b1, 8'(60 + i), 8'h80, 2'd1, 1'b0);
      if (i == 0) q4.delete();
      check("bypass_valid", if4.o_valid, 1'b1);
    end
    byp = 1'b0;
    send(1'b1, 8'd70, 8'd1, 2'd1, 1'b0);
    ex = '{60, 61, 62, 63, 64, 65};
    check_list("os4_bypass", q4, ex);
    send(1'b0, 8'd0, 8'd0, 2'd1, 1'b1);
    for (int i = 0; i < 8; i++) send(1'b1, 8'(71 + i), 8'hF0, 2'd1, 1'b0);

    // Async reset mid-stream clears outputs without a clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_data4", if4.o_data, 16'h0);
    check("async_rst_data3", if3.o_data, 16'h0);
    check("async_rst_phase4", if4.o_phase, 2'd0);
    check("async_rst_bit3", if3.o_bit, 2'b00);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) send(1'b1, 8'(90 + i), 8'd2, 2'd0, 1'b0);
    vld = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
